// File: rtl/ysyx_23060236_muldiv.sv
`default_nettype none
// ============================================================================
// ysyx_23060236_muldiv -- iterative RV32M multiply/divide unit (shift-add, restoring divide)
// Revision 1.0
// ============================================================================
module ysyx_23060236_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(XLEN / MUL_BITS);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic [XLEN-1:0]    mcand;
    logic [2*XLEN-1:0]  acc;
    logic               neg;
    logic [CNT_W-1:0]   cnt;

    logic               s1_signed, s2_signed, s1_neg, s2_neg;
    logic [XLEN-1:0]    mag1, mag2;
    logic               div_zero, div_ovf;
    logic [XLEN-1:0]    early_res;

    logic [XLEN+MUL_BITS-1:0] pp, psum;
    logic [2*XLEN-1:0]  mul_next, mul_fix;
    logic [XLEN-1:0]    mul_res;
    logic [XLEN:0]      rem_sh, diff;
    logic [2*XLEN-1:0]  div_next;
    logic [XLEN-1:0]    quo, rem, div_res;

    assign in_ready  = (state == IDLE) & ~flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Operand decode: funct3[2] selects divide; REM/DIV/MUL* signedness follows RV M.
    always_comb begin
        s1_signed = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
        s2_signed = in_op[2] ? ~in_op[0] : ~in_op[1];
        s1_neg    = s1_signed & src1[XLEN-1];
        s2_neg    = s2_signed & src2[XLEN-1];
        mag1      = s1_neg ? -src1 : src1;
        mag2      = s2_neg ? -src2 : src2;
        div_zero  = (src2 == '0);
        div_ovf   = ~in_op[0] & (src1 == MIN_NEG) & (src2 == '1);
        if (div_zero)
            early_res = in_op[1] ? src1 : '1;
        else
            early_res = in_op[1] ? '0 : src1;
    end

    // One shift-add step: high half absorbs mcand*digit, then the pair shifts right.
    always_comb begin
        pp       = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
        psum     = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + pp;
        mul_next = {psum, acc[XLEN-1:MUL_BITS]};
        mul_fix  = neg ? -mul_next : mul_next;
        mul_res  = (op[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

    // One restoring step: acc = {partial remainder, dividend/quotient}.
    always_comb begin
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, mcand};
        div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        if (op[1])
            div_res = neg ? -rem : rem;
        else
            div_res = neg ? -quo : quo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            mcand      <= '0;
            acc        <= '0;
            neg        <= 1'b0;
            cnt        <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op      <= in_op;
                        out_tag <= in_tag;
                        neg     <= (in_op[2] & in_op[1]) ? s1_neg : (s1_neg ^ s2_neg);
                        if (!in_op[2]) begin
                            mcand <= mag1;
                            acc   <= {{XLEN{1'b0}}, mag2};
                            cnt   <= MUL_CNT;
                            state <= MUL;
                        end else if (div_zero || div_ovf) begin
                            out_result <= early_res;
                            cnt        <= '0;
                            state      <= DONE;
                        end else begin
                            mcand <= mag2;
                            acc   <= {{XLEN{1'b0}}, mag1};
                            cnt   <= DIV_CNT;
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_result <= mul_res;
                        state      <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_result <= div_res;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_muldiv.sv
`default_nettype none
// Scoreboard bench for ysyx_23060236_muldiv: MUL_BITS=1 main instance plus a MUL_BITS=4 instance.
module tb_ysyx_23060236_muldiv;

    logic        clock = 1'b0;
    logic        reset, flush, out_ready;
    logic        in_valid, in_valid4;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic [31:0] src1, src2;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] out_result4;
    logic [4:0]  out_tag4;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          at;
    } exp_t;
    exp_t q[$];
    exp_t q4[$];

    ysyx_23060236_muldiv #(.XLEN(32), .MUL_BITS(1), .TAG_W(5)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy));

    ysyx_23060236_muldiv #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) u_dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_op(in_op), .in_tag(in_tag), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
        .out_tag(out_tag4), .busy(busy4));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the MUL_BITS=1 instance: latency, result, tag, and hold stability.
    logic        prev_v = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    always @(negedge clock) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.at);
                    chk("result", out_result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                end
                held_res = out_result;
                held_tag = out_tag;
            end else if (out_valid) begin
                chk("hold_result", out_result, held_res);
                chk("hold_tag", 32'(out_tag), 32'(held_tag));
            end
            prev_v = out_valid;
        end
    end

    logic prev_v4 = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            prev_v4 = 1'b0;
        end else begin
            if (out_valid4 && !prev_v4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_out_valid4", 32'(out_valid4), 32'd0);
                end else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("latency4", cyc, e.at);
                    chk("result4", out_result4, e.res);
                    chk("tag4", 32'(out_tag4), 32'(e.tag));
                end
            end
            prev_v4 = out_valid4;
        end
    end

    // Called at a negedge; returns at the following negedge with operands scrambled.
    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                         input int lat, input bit want, output int t);
        int guard = 0;
        while (((sel == 0) ? !in_ready : !in_ready4) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("accept_ready", 32'((sel == 0) ? in_ready : in_ready4), 32'd1);
        in_op = op; src1 = a; src2 = b; in_tag = tag;
        if (sel == 0) in_valid = 1'b1; else in_valid4 = 1'b1;
        t = cyc;
        if (want) begin
            if (sel == 0) q.push_back('{exp, tag, t + lat});
            else          q4.push_back('{exp, tag, t + lat});
        end
        @(negedge clock);
        in_valid = 1'b0; in_valid4 = 1'b0;
        src1 = $urandom; src2 = $urandom; in_op = 3'($urandom); in_tag = 5'($urandom);
    endtask

    task automatic wait_idle(input int sel);
        int guard = 0;
        while (((sel == 0) ? (busy | out_valid) : (busy4 | out_valid4)) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("idle_timeout", 32'((sel == 0) ? busy : busy4), 32'd0);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat);
        int t;
        issue(0, op, a, b, tag, exp, lat, 1'b1, t);
        wait_idle(0);
    endtask

    initial begin
        int t;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_valid4 = 1'b0; in_op = '0; in_tag = '0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clock);

        run(3'b000, 32'd7,        32'd6,        5'd3,  32'h0000002A, 33);
        run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 33);
        run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
        run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33);
        run(3'b000, 32'hFFFFFFFD, 32'd5,        5'd7,  32'hFFFFFFF1, 33);
        run(3'b011, 32'h80000000, 32'd4,        5'd8,  32'h00000002, 33);
        run(3'b101, 32'd100,      32'd0,        5'd9,  32'hFFFFFFFF, 1);
        run(3'b111, 32'd100,      32'd0,        5'd10, 32'd100,      1);
        run(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        run(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1);
        run(3'b100, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 33);
        run(3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 33);
        run(3'b101, 32'd100,      32'd7,        5'd15, 32'd14,       33);
        run(3'b111, 32'd100,      32'd7,        5'd16, 32'd2,        33);
        run(3'b100, 32'd7,        32'hFFFFFFFE, 5'd17, 32'hFFFFFFFD, 33);
        run(3'b110, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        33);

        // Flush a DIVU at T+10; a MUL must be accepted at T+11.
        issue(0, 3'b101, 32'd1000, 32'd3, 5'd1, 32'd0, 0, 1'b0, t);
        while (cyc < t + 10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        issue(0, 3'b000, 32'd3, 32'd5, 5'd19, 32'd15, 33, 1'b1, t);
        chk("flush_accept_cycle", t, 0 + cyc - 1);
        wait_idle(0);

        // Back-pressure: result held for 5 cycles, then handshake.
        out_ready = 1'b0;
        issue(0, 3'b000, 32'd9, 32'd9, 5'd20, 32'd81, 33, 1'b1, t);
        while (cyc < t + 33) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        #1;
        chk("hs_valid", 32'(out_valid), 32'd1);
        chk("hs_in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-DIV aborts without a result.
        issue(0, 3'b100, 32'd50, 32'd5, 5'd21, 32'd0, 0, 1'b0, t);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_result", out_result, 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clock);

        // MUL_BITS=4 instance: 7*6 with out_valid at T+9.
        issue(1, 3'b000, 32'd7, 32'd6, 5'd3, 32'h0000002A, 9, 1'b1, t);
        wait_idle(1);
        run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd22, 32'h00000000, 33);

        repeat (40) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("queue4_drained", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060236_muldiv.md
YSYX_23060236_MULDIV -- requirements
Module: ysyx_23060236_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, even, >=8.
REQ-002 SHALL have parameter MUL_BITS, default 1: multiplier bits retired per cycle; SHALL divide XLEN exactly; allowed values 1, 2 and 4.
REQ-003 SHALL have parameter TAG_W, default 5: width of the sideband tag (destination register index).
REQ-004 SHALL have port clock  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operation offered.
REQ-007 SHALL have port in_ready  output  1  unit can accept an operation this cycle.
REQ-008 SHALL have port in_op  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-010 SHALL have port src1  input  XLEN  multiplicand or dividend.
REQ-011 SHALL have port src2  input  XLEN  multiplier or divisor.
REQ-012 SHALL have port flush  input  1  kill the in-flight or pending operation.
REQ-013 SHALL have port out_valid  output  1  result available.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result.
REQ-015 SHALL have port out_result  output  XLEN  result.
REQ-016 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-019 in_ready SHALL equal (state==IDLE) & ~flush; an operation is accepted in cycle T when in_valid & in_ready.
REQ-020 On accept, the unit SHALL register in_op, in_tag and both operands, already sign- or zero-adjusted per in_op.
REQ-021 On accept of a multiply, the next state SHALL be MUL.
- Iterative shift-add on magnitudes, MUL_BITS bits per cycle, 2*XLEN-bit accumulator.
- Signs SHALL be fixed up at the end (negate product if operand signs differ).
- The transition to DONE SHALL occur so that out_valid is first high at T+XLEN/MUL_BITS+1.
REQ-022 MUL SHALL return the low XLEN bits; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
- Signedness: MULH signed x signed; MULHSU signed src1 x unsigned src2; MULHU unsigned x unsigned.
REQ-023 On accept of a divide, the next state SHALL be DIV.
- Restoring division, one quotient bit per cycle, on magnitudes.
- Quotient sign = XOR of operand signs; remainder sign = dividend sign.
- out_valid SHALL be first high at T+XLEN+1.
REQ-024 Divide-by-zero (src2==0) SHALL skip DIV, go directly to DONE and raise out_valid at T+1.
- DIV/DIVU result = all ones.
- REM/REMU result = src1.
REQ-025 Signed overflow (DIV/REM, src1 = 1 followed by XLEN-1 zeros, src2 = all ones) SHALL go directly to DONE and raise out_valid at T+1.
- DIV result = src1.
- REM result = 0.
REQ-026 In DONE: out_valid=1, and out_result and out_tag SHALL be held stable until the cycle where out_ready=1.
- That handshake cycle SHALL return the FSM to IDLE.
- No new operation SHALL be accepted in that cycle; the next accept is possible one cycle later.
REQ-027 out_valid SHALL be 0 in every state other than DONE.
REQ-028 flush=1 in any state SHALL force IDLE next cycle and discard the operation.
- No out_valid pulse SHALL be produced for the killed operation.
- An in_valid in the same cycle is not accepted (flush wins).
REQ-029 flush and out_ready both high in DONE SHALL count as a completed handshake; the result is consumed, then the FSM goes to IDLE.
REQ-030 The iteration counter SHALL be $clog2(XLEN)+1 bits wide; it is loaded at accept and counts down to zero with no wrap-around.
REQ-031 Operand changes on src1, src2, in_op or in_tag after accept SHALL NOT affect the in-flight result.

Reset
REQ-032 With reset=1 at a clock edge the unit SHALL enter IDLE, with out_valid=0, busy=0, out_result=0, out_tag=0 and counter=0.
REQ-033 Reset mid-MUL, mid-DIV or in DONE SHALL abort the operation without emitting a result.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 MUL, src1=7, src2=6, tag=3, out_ready=1 -> out_valid first at T+33 (MUL_BITS=1); result 0x0000002A, tag 3.
REQ-036 MULH, src1=src2=0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-037 DIVU 100/0 -> 0xFFFFFFFF at T+1; REMU 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM with the same operands -> 0.
REQ-038 DIV -7/2 -> 0xFFFFFFFD at T+33; REM -7/2 -> 0xFFFFFFFF.
REQ-039 Start DIVU, flush at T+10 -> IDLE at T+11; no out_valid; a new MUL 3*5 is accepted at T+11 and returns 15.
REQ-040 Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_result and out_tag stable; in_ready=0; out_ready=1 -> IDLE the next cycle; re-run REQ-035 with MUL_BITS=4 -> out_valid at T+9.
